// File: rtl/wb_pkg.sv
// +--------------------------------------------------------------------------+
// | wb_pkg: shared types and constants for the write-back merge stage. Rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

package wb_pkg;
  localparam int WB_DEPTH  = 2;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;
  localparam int REG_ZERO  = 0;

  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// +--------------------------------------------------------------------------+
// | wb_fifo: in-order MDU result buffer with WAW kill and pend-mask. Rev 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              push_live_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] kill_addr_i,
  output logic              ready_o,
  output logic              head_live_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [31:0]       pend_mask_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  live_q, live_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;

  always_comb begin
    live_d = live_q;
    addr_d = addr_q;
    data_d = data_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && (addr_q[i] == kill_addr_i)) live_d[i] = 1'b0;
    end
    // Popped slots drop their live bit so stale addresses never reach the mask.
    if (pop_i) begin
      live_d[rd_q] = 1'b0;
      rd_d         = rd_q + 1'b1;
    end
    if (push_i) begin
      live_d[wr_q] = push_live_i;
      addr_d[wr_q] = push_addr_i;
      data_d[wr_q] = push_data_i;
      wr_d         = wr_q + 1'b1;
    end
    cnt_d   = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    ready_d = (cnt_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      live_q  <= live_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pend_mask_o[addr_q[i]] = 1'b1;
    end
  end

  assign ready_o     = ready_q;
  assign count_o     = cnt_q;
  assign head_live_o = live_q[rd_q];
  assign head_addr_o = addr_q[rd_q];
  assign head_data_o = data_q[rd_q];
endmodule

`default_nettype wire

// File: rtl/wb_merge.sv
// +--------------------------------------------------------------------------+
// | wb_merge: merges pipeline and MDU writes onto one regfile port. Rev 1.0   |
// | Optional same-cycle MDU bypass when WB_MERGE_BYPASS_EN is defined.        |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_merge
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       pipe_we_i,
  input  logic [ADDR_W-1:0]          pipe_addr_i,
  input  logic [DATA_W-1:0]          pipe_data_i,
  input  logic                       mdu_valid_i,
  input  logic [ADDR_W-1:0]          mdu_addr_i,
  input  logic [DATA_W-1:0]          mdu_data_i,
  output logic                       mdu_ready_o,
  output logic                       RegWrite_o,
  output logic [ADDR_W-1:0]          RDaddr_o,
  output logic [DATA_W-1:0]          RDdata_o,
  output logic [31:0]                pend_mask_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  logic              slot_busy, xfer, mdu_nz, head_valid, bypass;
  logic              push, push_live, pop, drain;
  logic              head_live;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    // Pipe inputs are ignored while reset is held so outputs stay at zero.
    slot_busy  = !rst_i && pipe_we_i && (pipe_addr_i != ADDR_W'(REG_ZERO));
    xfer       = mdu_valid_i && mdu_ready_o;
    mdu_nz     = (mdu_addr_i != ADDR_W'(REG_ZERO));
    head_valid = (count_o != '0);
`ifdef WB_MERGE_BYPASS_EN
    bypass     = xfer && mdu_nz && !head_valid && !slot_busy;
`else
    bypass     = 1'b0;
`endif
    push       = xfer && mdu_nz && !bypass;
    push_live  = !(slot_busy && (pipe_addr_i == mdu_addr_i));
    drain      = head_valid && head_live && !slot_busy;
    pop        = head_valid && (!head_live || !slot_busy);

    RegWrite_o = 1'b0;
    RDaddr_o   = '0;
    RDdata_o   = '0;
    if (slot_busy) begin
      RegWrite_o = 1'b1;
      RDaddr_o   = pipe_addr_i;
      RDdata_o   = pipe_data_i;
    end else if (drain) begin
      RegWrite_o = 1'b1;
      RDaddr_o   = head_addr;
      RDdata_o   = head_data;
    end else if (bypass) begin
      RegWrite_o = 1'b1;
      RDaddr_o   = mdu_addr_i;
      RDdata_o   = mdu_data_i;
    end
  end

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  ($clog2(DEPTH + 1))
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_live_i (push_live),
    .push_addr_i (mdu_addr_i),
    .push_data_i (mdu_data_i),
    .pop_i       (pop),
    .kill_i      (slot_busy),
    .kill_addr_i (pipe_addr_i),
    .ready_o     (mdu_ready_o),
    .head_live_o (head_live),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (count_o),
    .pend_mask_o (pend_mask_o)
  );
endmodule

`default_nettype wire

// File: doc/wb_merge.md
# wb_merge

Write-back merge stage that sits directly upstream of the register-file write port. It combines the main pipeline's MEM/WB write with results from a long-latency multiply/divide unit (MDU) into a single write per cycle. The pipeline always has priority; MDU results wait in a small in-order buffer until a free write slot. The block publishes a pending-register mask so the hazard unit can stall readers of registers whose MDU result has not yet been written.

## Interface
- DEPTH, 2, buffer entries; legal values 2 or 4
- DATA_W, 32, data width
- ADDR_W, 5, register address width
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- pipe_we_i  in  1  pipeline write request (MEM/WB RegWrite)
- pipe_addr_i  in  ADDR_W  pipeline destination register
- pipe_data_i  in  DATA_W  pipeline write data
- mdu_valid_i  in  1  MDU result valid
- mdu_addr_i  in  ADDR_W  MDU destination register
- mdu_data_i  in  DATA_W  MDU result
- mdu_ready_o  out  1  buffer can accept an MDU result
- RegWrite_o  out  1  write enable to register file
- RDaddr_o  out  ADDR_W  write address to register file
- RDdata_o  out  DATA_W  write data to register file
- pend_mask_o  out  32  bit i set while a live buffered entry targets register i
- count_o  out  $clog2(DEPTH+1)  occupied entries, live or killed

## Operation
- Pipeline slot is busy when pipe_we_i=1 and pipe_addr_i≠0. It then drives RegWrite_o=1, RDaddr_o=pipe_addr_i and RDdata_o=pipe_data_i in the same cycle.
- Pipeline write to register 0 is treated as an idle slot; RegWrite_o=0 for it.
- MDU transfer occurs on a cycle where mdu_valid_i=1 and mdu_ready_o=1.
- The MDU holds valid, addr and data stable until the transfer.
- mdu_ready_o = (count_o < DEPTH). It is derived from registered state only and never depends on mdu_valid_i.
- A transferred result with addr 0 is accepted and discarded; it is never enqueued.
- Each entry holds {live, addr, data}. Entries are FIFO-ordered.
- Drain: when the slot is idle and the head entry is live, the head is written (RegWrite_o=1) and popped.
- A killed head pops in any cycle with no write, whether the slot is busy or idle.
- Kill (WAW): a busy pipeline write to A clears `live` on every buffered entry with addr A. The pipeline instruction is younger, so its value wins.
- Same-cycle case: an MDU transfer to A together with a busy pipeline write to A enqueues the entry already killed.
- Enqueue and dequeue in the same cycle are allowed; count_o is unchanged.
- pend_mask_o is the OR of the one-hot addr of all live entries, computed from registered state.
- Outputs RegWrite_o, RDaddr_o and RDdata_o are combinational from the pipe inputs and the buffer head.
- RDaddr_o and RDdata_o are 0 whenever RegWrite_o=0.

## Timing
- Reset asserted (asynchronous): count_o=0, all live bits=0, pend_mask_o=0, mdu_ready_o=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0. The pipe inputs are ignored.
- First rising edge after rst_i deasserts: mdu_ready_o=1.
- Reset mid-operation discards all buffered entries. No partial writes occur.
- Pipeline write: zero added latency.
- MDU result without bypass: accepted at edge N, earliest RegWrite_o in cycle N+1.
- Each cycle the slot is busy delays the drain by one cycle.
- pend_mask_o sets one cycle after transfer. It clears one cycle after the drain or kill.
- Full (count_o=DEPTH): mdu_ready_o=0 until a pop occurs.
- mdu_ready_o rises the cycle after the popping edge.

## Configuration
- WB_MERGE_BYPASS_EN defined: when the buffer is empty, the slot is idle, and a live MDU result with addr≠0 transfers, it is written to the register file in the same cycle and is not enqueued. pend_mask_o never shows it.
- WB_MERGE_BYPASS_EN undefined: every MDU result passes through the buffer, with a minimum latency of one cycle.

## Structure
- Package wb_pkg holds:
  - typedef wb_entry_t {live, addr, data}
  - constant REG_ZERO=0
  - default WB_DEPTH=2
- Sub-module wb_fifo holds the entry storage, pointers, count, per-entry kill-match and the pend-mask generation.
- wb_merge holds slot arbitration, the drain decision and the output mux.

## Test plan
- Reset, then MDU writes $8=0x11 with the pipe idle: RegWrite_o=1, addr 8, data 0x11 one cycle after acceptance (same cycle with bypass). pend_mask_o[8] pulses for one cycle without bypass.
- Pipe busy writing $3 for 4 cycles while the MDU sends $9=0xAA and $10=0xBB (DEPTH=2): mdu_ready_o=0 after the second transfer. Writes then appear in order $9, $10 after pipe_we_i drops. count_o returns to 0.
- MDU $5=0x1 buffered, then a pipe write to $5=0x2: register file receives only 0x2. The killed entry pops with no write. pend_mask_o[5] clears next cycle.
- MDU transfer to $7 in the same cycle as a pipe write to $7=0x70: only 0x70 is written. count_o goes 1→0 with no MDU write.
- MDU result to $0 and pipe write to $0: RegWrite_o stays 0 and count_o stays 0.
- rst_i asserted with 2 live entries: all outputs are 0 immediately. After release, no stale writes occur and mdu_ready_o=1 after one edge.
